// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave.
// Completer FSM encodings, wait-counter sizing and strobe-width helper.
package apb_pkg;

    typedef logic [1:0] apb_state_t;

    localparam apb_state_t ST_IDLE  = 2'd0;
    localparam apb_state_t ST_WAIT  = 2'd1;
    localparam apb_state_t ST_READY = 2'd2;

    localparam int APB_MAX_WAIT = 15;
    localparam int APB_CNT_W    = 4;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage with per-byte write enables.
// Read data is registered; clear takes priority over a read load.
module apb_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [IDX_W-1:0]            i_addr,
    input  logic                        i_we,
    input  logic [strb_w(DATA_W)-1:0]   i_be,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic                        i_re,
    input  logic                        i_clr,
    output logic [DATA_W-1:0]           o_rdata
);

    localparam int NB = strb_w(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb_mem_slave.sv
// APB3/APB4 completer in front of a byte-writable register file.
// Registered PREADY/PSLVERR/PRDATA, configurable access wait states.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                        i_pclk,
    input  logic                        i_presetn,
    input  logic                        i_psel,
    input  logic                        i_penable,
    input  logic                        i_pwrite,
    input  logic [ADDR_W-1:0]           i_paddr,
    input  logic [DATA_W-1:0]           i_pwdata,
    input  logic [strb_w(DATA_W)-1:0]   i_pstrb,
    output logic [DATA_W-1:0]           o_prdata,
    output logic                        o_pready,
    output logic                        o_pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
    localparam logic [APB_CNT_W-1:0] CNT_INIT =
        NO_WAIT ? '0 : APB_CNT_W'(WAIT_STATES - 1);

    apb_state_t             r_state;
    logic [APB_CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_write;
    logic                   r_err;
    logic                   r_pready;
    logic                   r_pslverr;

    logic                   w_idle;
    logic                   w_setup;
    logic                   w_setup_err;
    logic                   w_enter_rdy;
    logic                   w_leave_rdy;
    logic                   w_complete;
    logic                   w_rd_write;
    logic                   w_rd_err;
    logic                   w_re;
    logic                   w_we;
    logic [IDX_W-1:0]       w_idx;
    logic [DATA_W-1:0]      w_rdata;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_setup     = w_idle & i_psel & ~i_penable;
    assign w_setup_err = ({1'b0, i_paddr} >= DEPTH_A);

    assign w_enter_rdy = (w_setup & NO_WAIT)
                       | ((r_state == ST_WAIT) & i_psel
                          & (r_cnt == '0));
    assign w_complete  = (r_state == ST_READY) & i_psel & i_penable;
    assign w_leave_rdy = (r_state == ST_READY) & (~i_psel | i_penable);

    // With zero wait states the read is issued from the live setup-phase bus.
    assign w_rd_write = w_idle ? i_pwrite : r_write;
    assign w_rd_err   = w_idle ? w_setup_err : r_err;
    assign w_idx      = w_idle ? i_paddr[IDX_W-1:0] : r_idx;

    assign w_re = w_enter_rdy & ~w_rd_write & ~w_rd_err;
    assign w_we = w_complete & r_write & ~r_err;

    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_write   <= 1'b0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_idx   <= i_paddr[IDX_W-1:0];
                        r_write <= i_pwrite;
                        r_err   <= w_setup_err;
                        if (NO_WAIT) begin
                            r_state   <= ST_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_setup_err;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_psel) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state   <= ST_READY;
                        r_pready  <= 1'b1;
                        r_pslverr <= r_err;
                    end else begin
                        r_cnt <= r_cnt - APB_CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (w_leave_rdy) begin
                        r_state   <= ST_IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .i_clk   (i_pclk),
        .i_rst_n (i_presetn),
        .i_addr  (w_idx),
        .i_we    (w_we),
        .i_be    (i_pstrb),
        .i_wdata (i_pwdata),
        .i_re    (w_re),
        .i_clr   (w_leave_rdy),
        .o_rdata (w_rdata)
    );

    assign o_prdata  = w_rdata;
    assign o_pready  = r_pready;
    assign o_pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave with 0, 2 and 3 wait states.
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_apb_mem_slave;

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [7:0]  paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int   ws [3] = '{0, 2, 3};
    exp_t sb [$];
    exp_t mon_e;
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    int   start;

    apb_mem_slave #(.WAIT_STATES(0)) u0 (
        .i_pclk(clk), .i_presetn(rst_n),
        .i_psel(psel[0]), .i_penable(penable[0]),
        .i_pwrite(pwrite[0]), .i_paddr(paddr[0]),
        .i_pwdata(pwdata[0]), .i_pstrb(pstrb[0]),
        .o_prdata(prdata[0]), .o_pready(pready[0]),
        .o_pslverr(pslverr[0])
    );

    apb_mem_slave #(.WAIT_STATES(2)) u1 (
        .i_pclk(clk), .i_presetn(rst_n),
        .i_psel(psel[1]), .i_penable(penable[1]),
        .i_pwrite(pwrite[1]), .i_paddr(paddr[1]),
        .i_pwdata(pwdata[1]), .i_pstrb(pstrb[1]),
        .o_prdata(prdata[1]), .o_pready(pready[1]),
        .o_pslverr(pslverr[1])
    );

    apb_mem_slave #(.WAIT_STATES(3)) u2 (
        .i_pclk(clk), .i_presetn(rst_n),
        .i_psel(psel[2]), .i_penable(penable[2]),
        .i_pwrite(pwrite[2]), .i_paddr(paddr[2]),
        .i_pwdata(pwdata[2]), .i_pstrb(pstrb[2]),
        .o_prdata(prdata[2]), .o_pready(pready[2]),
        .o_pslverr(pslverr[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pready[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].d != 2'(d)) begin
                    nvec++;
                    nerr++;
                    $display("FAIL unexpected_pready d%0d: got 1, expected 0",
                             d);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("prdata d%0d", d), prdata[d], mon_e.rd);
                    chk($sformatf("pslverr d%0d", d),
                        {31'b0, pslverr[d]}, {31'b0, mon_e.err});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] er, input bit ee);
        int   n;
        exp_t e;
        e.d   = 2'(d);
        e.rd  = er;
        e.err = ee;
        sb.push_back(e);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = a;
        pwdata[d]  = wd;
        pstrb[d]   = st;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        paddr[d]   = ~a;
        pwrite[d]  = ~wr;
        n = 0;
        while (pready[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("wait_cycles d%0d a%0d", d, a), 32'(n), 32'(ws[d]));
        @(posedge clk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic chk_quiet(input string nm, input int d);
        chk({nm, "_pready"},  {31'b0, pready[d]},  32'h0);
        chk({nm, "_pslverr"}, {31'b0, pslverr[d]}, 32'h0);
        chk({nm, "_prdata"},  prdata[d],           32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
            paddr[d] = 0; pwdata[d] = 0; pstrb[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_quiet($sformatf("reset_d%0d", d), d);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero wait states: full write, byte strobes, errors
        xfer(0, 1, 8'd63, 32'h63636363, 4'hF, 32'h0, 1'b0);
        xfer(0, 1, 8'd5,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer(0, 0, 8'd5,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
        xfer(0, 1, 8'd3,  32'hFFFFFFFF, 4'hF, 32'h0, 1'b0);
        xfer(0, 1, 8'd3,  32'h00000000, 4'b0101, 32'h0, 1'b0);
        xfer(0, 0, 8'd3,  32'h0,        4'hF, 32'hFF00FF00, 1'b0);
        xfer(0, 1, 8'd3,  32'h12345678, 4'h0, 32'h0, 1'b0);
        xfer(0, 0, 8'd3,  32'h0,        4'hF, 32'hFF00FF00, 1'b0);
        xfer(0, 1, 8'd64, 32'hBAD0BAD0, 4'hF, 32'h0, 1'b1);
        xfer(0, 0, 8'd64, 32'h0,        4'hF, 32'h0, 1'b1);
        xfer(0, 0, 8'd63, 32'h0,        4'hF, 32'h63636363, 1'b0);

        // Access phase without a setup phase is ignored
        psel[0] = 1'b1; penable[0] = 1'b1;
        @(posedge clk); #1;
        chk("illegal_access_pready", {31'b0, pready[0]}, 32'h0);
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        chk("illegal_access_after", {31'b0, pready[0]}, 32'h0);

        // Three wait states
        xfer(2, 1, 8'd0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        xfer(2, 0, 8'd0, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0);

        // Two wait states: abort a write after its first access cycle
        xfer(1, 1, 8'd7, 32'hAAAA5555, 4'hF, 32'h0, 1'b0);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'd7; pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_quiet($sformatf("abort_c%0d", i), 1);
            @(posedge clk); #1;
        end
        xfer(1, 0, 8'd7, 32'h0, 4'hF, 32'hAAAA5555, 1'b0);
        xfer(1, 1, 8'd9, 32'h11111111, 4'hF, 32'h0, 1'b0);

        // Reset hits u0 in READY and u1 in WAIT of a write
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0;
        paddr[0] = 8'd5;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'd9; pwdata[1] = 32'h22222222; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[0] = 1'b1; penable[1] = 1'b1;
        chk("pre_reset_pready", {31'b0, pready[0]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("async_rst_d0", 0);
        chk_quiet("async_rst_d1", 1);
        psel[0] = 0; penable[0] = 0; psel[1] = 0; penable[1] = 0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 8'd9, 32'h0, 4'hF, 32'h11111111, 1'b0);

        // Back-to-back reads after reset
        start = cyc;
        xfer(0, 0, 8'd5,  32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        xfer(0, 0, 8'd3,  32'h0, 4'hF, 32'hFF00FF00, 1'b0);
        xfer(0, 0, 8'd63, 32'h0, 4'hF, 32'h63636363, 1'b0);
        xfer(0, 0, 8'd5,  32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        chk("b2b_cycles", 32'(cyc - start), 32'd8);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
